// File: rtl/instruction_decode_pkg.sv
// Shared ISA constants for decode and ALU: opcodes, functs, ALU control encodings, NOP.
package instruction_decode_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111
   } alu_ctrl_t;

   typedef struct packed {
      logic      reg_write;
      logic      mem_to_reg;
      logic      mem_write;
      logic      alu_src;
      logic      reg_dst;
      alu_ctrl_t alu_ctrl;
      logic      illegal;
   } ctrl_t;

   function automatic logic [31:0] sign_ext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32x32 register file, one synchronous write port and two combinational read ports; r0 reads 0.
// With REGFILE_BYPASS_EN defined, a same-cycle write is forwarded to a matching read port.
module register_file
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata
);

   logic [31:0] regs [32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && waddr != 5'd0) begin
         regs[waddr] <= wdata;
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic wr_live;
   assign wr_live = we && (waddr != 5'd0);
   assign rdata1  = (raddr1 == 5'd0) ? 32'd0 : (wr_live && waddr == raddr1) ? wdata : regs[raddr1];
   assign rdata2  = (raddr2 == 5'd0) ? 32'd0 : (wr_live && waddr == raddr2) ? wdata : regs[raddr2];
`else
   assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];
`endif

endmodule

// File: rtl/instruction_decode.sv
// ID stage: decode + register read, registered into E one cycle later; StallD is a combinational
// load-use stall that inserts one bubble. REGFILE_BYPASS_EN enables same-cycle write forwarding.
module instruction_decode
   import instruction_decode_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] InstrD,
   input  logic        RegWriteW,
   input  logic [4:0]  WriteRegW,
   input  logic [31:0] ResultW,
   output logic        StallD,
   output logic        RegWriteE,
   output logic        MemToRegE,
   output logic        MemWriteE,
   output logic        ALUSrcE,
   output logic        RegDstE,
   output logic [3:0]  ALUControlE,
   output logic [4:0]  RsE,
   output logic [4:0]  RtE,
   output logic [4:0]  RdE,
   output logic [31:0] SignImmE,
   output logic [31:0] value1,
   output logic [31:0] value2,
   output logic        IllegalE
);

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   ctrl_t       dec_ctrl;
   ctrl_t       ctrl_e;
   logic        uses_rt;
   logic        m2r_q;
   logic [4:0]  rt_q;

   assign op    = InstrD[31:26];
   assign rs    = InstrD[25:21];
   assign rt    = InstrD[20:16];
   assign rd    = InstrD[15:11];
   assign funct = InstrD[5:0];

   register_file u_register_file (
      .clk    (clk),
      .rst_n  (rst_n),
      .raddr1 (rs),
      .raddr2 (rt),
      .rdata1 (rdata1),
      .rdata2 (rdata2),
      .we     (RegWriteW),
      .waddr  (WriteRegW),
      .wdata  (ResultW)
   );

   always_comb begin
      dec_ctrl = '0;
      if (InstrD != NOP_INSTR) begin
         case (op)
            OP_RTYPE: begin
               dec_ctrl.reg_write = 1'b1;
               dec_ctrl.reg_dst   = 1'b1;
               case (funct)
                  FN_ADD:  dec_ctrl.alu_ctrl = ALU_ADD;
                  FN_SUB:  dec_ctrl.alu_ctrl = ALU_SUB;
                  FN_AND:  dec_ctrl.alu_ctrl = ALU_AND;
                  FN_OR:   dec_ctrl.alu_ctrl = ALU_OR;
                  FN_SLT:  dec_ctrl.alu_ctrl = ALU_SLT;
                  default: begin
                     dec_ctrl         = '0;
                     dec_ctrl.illegal = 1'b1;
                  end
               endcase
            end
            OP_LW: begin
               dec_ctrl.reg_write  = 1'b1;
               dec_ctrl.mem_to_reg = 1'b1;
               dec_ctrl.alu_src    = 1'b1;
               dec_ctrl.alu_ctrl   = ALU_ADD;
            end
            OP_SW: begin
               dec_ctrl.mem_write = 1'b1;
               dec_ctrl.alu_src   = 1'b1;
               dec_ctrl.alu_ctrl  = ALU_ADD;
            end
            OP_ADDI: begin
               dec_ctrl.reg_write = 1'b1;
               dec_ctrl.alu_src   = 1'b1;
               dec_ctrl.alu_ctrl  = ALU_ADD;
            end
            default: dec_ctrl.illegal = 1'b1;
         endcase
      end
   end

   // Only R-type and sw actually source Rt; for lw/addi it is a destination.
   assign uses_rt = (op == OP_RTYPE) || (op == OP_SW);
   assign StallD  = m2r_q && (rt_q != 5'd0) && ((rt_q == rs) || (uses_rt && rt_q == rt));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_e   <= '0;
         RsE      <= '0;
         RtE      <= '0;
         RdE      <= '0;
         SignImmE <= '0;
         value1   <= '0;
         value2   <= '0;
         m2r_q    <= 1'b0;
         rt_q     <= '0;
      end else begin
         ctrl_e   <= StallD ? ctrl_t'('0) : dec_ctrl;
         RsE      <= rs;
         RtE      <= rt;
         RdE      <= rd;
         SignImmE <= sign_ext16(InstrD[15:0]);
         value1   <= rdata1;
         value2   <= rdata2;
         m2r_q    <= StallD ? 1'b0 : dec_ctrl.mem_to_reg;
         rt_q     <= rt;
      end
   end

   assign RegWriteE   = ctrl_e.reg_write;
   assign MemToRegE   = ctrl_e.mem_to_reg;
   assign MemWriteE   = ctrl_e.mem_write;
   assign ALUSrcE     = ctrl_e.alu_src;
   assign RegDstE     = ctrl_e.reg_dst;
   assign ALUControlE = ctrl_e.alu_ctrl;
   assign IllegalE    = ctrl_e.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Table-driven bench for instruction_decode with a scoreboard queue of expected E-stage records.
module tb_instruction_decode;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] InstrD;
   logic        RegWriteW;
   logic [4:0]  WriteRegW;
   logic [31:0] ResultW;
   logic        StallD, RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE, IllegalE;
   logic [3:0]  ALUControlE;
   logic [4:0]  RsE, RtE, RdE;
   logic [31:0] SignImmE, value1, value2;

   int total = 0;
   int bad   = 0;

   instruction_decode dut (
      .clk(clk), .rst_n(rst_n), .InstrD(InstrD),
      .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
      .StallD(StallD), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
      .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
      .RsE(RsE), .RtE(RtE), .RdE(RdE), .SignImmE(SignImmE),
      .value1(value1), .value2(value2), .IllegalE(IllegalE)
   );

   always #5 clk = ~clk;

   // ctrl = {RegWrite, MemToReg, MemWrite, ALUSrc, RegDst, ALUControl[3:0], Illegal}
   localparam logic [10:0] C_ADD  = 11'b10001_0010_0;
   localparam logic [10:0] C_SUB  = 11'b10001_0110_0;
   localparam logic [10:0] C_AND  = 11'b10001_0000_0;
   localparam logic [10:0] C_OR   = 11'b10001_0001_0;
   localparam logic [10:0] C_SLT  = 11'b10001_0111_0;
   localparam logic [10:0] C_LW   = 11'b11010_0010_0;
   localparam logic [10:0] C_SW   = 11'b00110_0010_0;
   localparam logic [10:0] C_ADDI = 11'b10010_0010_0;
   localparam logic [10:0] C_ILL  = 11'b00000_0000_1;
   localparam logic [10:0] C_ZERO = 11'b00000_0000_0;

   typedef struct {
      string       nm;
      logic [31:0] instr;
      logic [10:0] ctrl;
      logic        data;
      logic [4:0]  rs, rt, rd;
      logic [31:0] imm, v1, v2;
   } vec_t;

   vec_t q[$];
   vec_t tbl[15];

   function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] fn);
      return {6'h00, s, t, d, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
      return {o, s, t, im};
   endfunction

   function automatic vec_t mk(input string nm, input logic [31:0] instr, input logic [10:0] ctrl,
                               input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                               input logic [31:0] imm, input logic [31:0] v1, input logic [31:0] v2);
      vec_t v;
      v.nm = nm; v.instr = instr; v.ctrl = ctrl; v.data = 1'b1;
      v.rs = s; v.rt = t; v.rd = d; v.imm = imm; v.v1 = v1; v.v2 = v2;
      return v;
   endfunction

   function automatic vec_t bubble(input string nm, input logic [31:0] instr);
      vec_t v;
      v = mk(nm, instr, C_ZERO, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
      v.data = 1'b0;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_e();
      vec_t v;
      if (q.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard: got empty queue expected a record");
      end else begin
         v = q.pop_front();
         chk({v.nm, ".ctrl"}, {21'd0, RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE,
                               ALUControlE, IllegalE}, {21'd0, v.ctrl});
         if (v.data) begin
            chk({v.nm, ".rs"},  {27'd0, RsE}, {27'd0, v.rs});
            chk({v.nm, ".rt"},  {27'd0, RtE}, {27'd0, v.rt});
            chk({v.nm, ".rd"},  {27'd0, RdE}, {27'd0, v.rd});
            chk({v.nm, ".imm"}, SignImmE, v.imm);
            chk({v.nm, ".v1"},  value1, v.v1);
            chk({v.nm, ".v2"},  value2, v.v2);
         end
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, ".stall"}, {31'd0, StallD}, 32'd0);
      chk({nm, ".ctrl"}, {21'd0, RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE,
                          ALUControlE, IllegalE}, 32'd0);
      chk({nm, ".regs"}, {17'd0, RsE, RtE, RdE}, 32'd0);
      chk({nm, ".imm"}, SignImmE, 32'd0);
      chk({nm, ".v1"}, value1, 32'd0);
      chk({nm, ".v2"}, value2, 32'd0);
   endtask

   // Called just after a rising edge: drive, check StallD mid-cycle, then check E after the next edge.
   task automatic step(input vec_t v, input logic exp_stall, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
      InstrD    = v.instr;
      RegWriteW = we;
      WriteRegW = wa;
      ResultW   = wd;
      q.push_back(v);
      @(negedge clk);
      chk({v.nm, ".stall"}, {31'd0, StallD}, {31'd0, exp_stall});
      @(posedge clk);
      #1;
      RegWriteW = 1'b0;
      check_e();
   endtask

   task automatic wr(input logic [4:0] r, input logic [31:0] val);
      step(mk("wr_nop", 32'd0, C_ZERO, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0), 1'b0, 1'b1, r, val);
   endtask

   initial begin
      logic [31:0] lw4, add544, i_or, i_r0;
      logic [31:0] exp_or;
      rst_n = 1'b0; InstrD = '0; RegWriteW = 1'b0; WriteRegW = '0; ResultW = '0;

      #12;
      chk_zero("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      wr(5'd1, 32'd5);
      wr(5'd2, 32'd7);
      wr(5'd4, 32'h44);
      wr(5'd7, 32'h1111);

      tbl[0]  = mk("add",   32'h0022_1820, C_ADD, 1, 2, 3, 32'h1820, 5, 7);
      tbl[1]  = mk("sub",   rtype(1, 2, 3, 6'h22), C_SUB, 1, 2, 3, 32'h1822, 5, 7);
      tbl[2]  = mk("and",   rtype(2, 1, 9, 6'h24), C_AND, 2, 1, 9, 32'h4824, 7, 5);
      tbl[3]  = mk("or",    rtype(1, 0, 10, 6'h25), C_OR, 1, 0, 10, 32'h5025, 5, 0);
      tbl[4]  = mk("slt",   rtype(1, 2, 11, 6'h2A), C_SLT, 1, 2, 11, 32'h582A, 5, 7);
      tbl[5]  = mk("lw",    itype(6'h23, 0, 4, 16'h0008), C_LW, 0, 4, 0, 32'h8, 0, 32'h44);
      tbl[6]  = mk("sw",    itype(6'h2B, 1, 2, 16'h0004), C_SW, 1, 2, 0, 32'h4, 5, 7);
      tbl[7]  = mk("addim1", 32'h2006_FFFF, C_ADDI, 0, 6, 31, 32'hFFFF_FFFF, 0, 0);
      tbl[8]  = mk("addi7f", itype(6'h08, 1, 6, 16'h7FFF), C_ADDI, 1, 6, 15, 32'h0000_7FFF, 5, 0);
      tbl[9]  = mk("addi80", itype(6'h08, 2, 6, 16'h8000), C_ADDI, 2, 6, 16, 32'hFFFF_8000, 7, 0);
      tbl[10] = mk("ill3f", 32'hFC00_0000, C_ILL, 0, 0, 0, 32'h0, 0, 0);
      tbl[11] = mk("nop",   32'h0, C_ZERO, 0, 0, 0, 32'h0, 0, 0);
      tbl[12] = mk("illfn", rtype(1, 2, 3, 6'h21), C_ILL, 1, 2, 3, 32'h1821, 5, 7);
      tbl[13] = mk("ill02", itype(6'h02, 0, 0, 16'h0010), C_ILL, 0, 0, 0, 32'h10, 0, 0);
      tbl[14] = mk("nop2",  32'h0, C_ZERO, 0, 0, 0, 32'h0, 0, 0);

      for (int i = 0; i < 15; i++) step(tbl[i], 1'b0, 1'b0, 5'd0, 32'd0);

      lw4    = itype(6'h23, 0, 4, 16'h0008);
      add544 = rtype(4, 4, 5, 6'h20);

      // load-use on Rs: one stall cycle, one bubble, then the add
      step(mk("lu_lw", lw4, C_LW, 0, 4, 0, 32'h8, 0, 32'h44), 1'b0, 1'b0, 5'd0, 32'd0);
      step(bubble("lu_bub", add544), 1'b1, 1'b0, 5'd0, 32'd0);
      step(mk("lu_add", add544, C_ADD, 4, 4, 5, 32'h2820, 32'h44, 32'h44), 1'b0, 1'b0, 5'd0, 32'd0);

      // load-use via Rt of a store
      step(mk("lus_lw", lw4, C_LW, 0, 4, 0, 32'h8, 0, 32'h44), 1'b0, 1'b0, 5'd0, 32'd0);
      step(bubble("lus_bub", itype(6'h2B, 1, 4, 16'h0)), 1'b1, 1'b0, 5'd0, 32'd0);
      step(mk("lus_sw", itype(6'h2B, 1, 4, 16'h0), C_SW, 1, 4, 0, 32'h0, 5, 32'h44),
           1'b0, 1'b0, 5'd0, 32'd0);

      // addi's Rt is a destination, so no stall
      step(mk("lua_lw", lw4, C_LW, 0, 4, 0, 32'h8, 0, 32'h44), 1'b0, 1'b0, 5'd0, 32'd0);
      step(mk("lua_addi", itype(6'h08, 0, 4, 16'h1), C_ADDI, 0, 4, 0, 32'h1, 0, 32'h44),
           1'b0, 1'b0, 5'd0, 32'd0);

      // load into r0 never stalls
      step(mk("lu0_lw", itype(6'h23, 1, 0, 16'h0), C_LW, 1, 0, 0, 32'h0, 5, 0), 1'b0, 1'b0, 5'd0, 32'd0);
      step(mk("lu0_add", rtype(0, 0, 5, 6'h20), C_ADD, 0, 0, 5, 32'h2820, 0, 0), 1'b0, 1'b0, 5'd0, 32'd0);

      // same-cycle write/read
      i_or = rtype(7, 0, 8, 6'h25);
`ifdef REGFILE_BYPASS_EN
      exp_or = 32'hDEAD;
`else
      exp_or = 32'h1111;
`endif
      step(mk("byp_or", i_or, C_OR, 7, 0, 8, 32'h4025, exp_or, 0), 1'b0, 1'b1, 5'd7, 32'hDEAD);
      step(mk("byp_or2", i_or, C_OR, 7, 0, 8, 32'h4025, 32'hDEAD, 0), 1'b0, 1'b0, 5'd0, 32'd0);
      i_r0 = rtype(0, 0, 9, 6'h20);
      step(mk("r0_wr", i_r0, C_ADD, 0, 0, 9, 32'h4820, 0, 0), 1'b0, 1'b1, 5'd0, 32'h55);
      step(mk("r0_rd", i_r0, C_ADD, 0, 0, 9, 32'h4820, 0, 0), 1'b0, 1'b0, 5'd0, 32'd0);

      // reset asserted while stalled
      step(mk("rs_lw", lw4, C_LW, 0, 4, 0, 32'h8, 0, 32'h44), 1'b0, 1'b0, 5'd0, 32'd0);
      InstrD = add544;
      @(negedge clk);
      chk("rs_stall_before", {31'd0, StallD}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_zero("rs_now");
      @(posedge clk); #1;
      chk_zero("rs_held");
      @(negedge clk); rst_n = 1'b1;
      #1 chk("rs_stall_after", {31'd0, StallD}, 32'd0);
      q.push_back(mk("rs_resume", add544, C_ADD, 4, 4, 5, 32'h2820, 0, 0));
      @(posedge clk); #1;
      check_e();
      step(mk("rs_rf", 32'h0022_1820, C_ADD, 1, 2, 3, 32'h1820, 0, 0), 1'b0, 1'b0, 5'd0, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous, active-low reset).
REQ-002 SHALL have InstrD input 32: the instruction fetched for decode, held stable by upstream while StallD=1.
REQ-003 SHALL have the writeback port RegWriteW input 1, WriteRegW input 5 and ResultW input 32, which together form the register-file write.
REQ-004 SHALL have StallD output 1: a combinational load-use stall request to fetch/IF-ID.
REQ-005 SHALL have these registered outputs to the execute stage: RegWriteE, MemToRegE, MemWriteE, ALUSrcE and RegDstE (each 1); ALUControlE 4; RsE, RtE and RdE (each 5); SignImmE, value1 and value2 (each 32); IllegalE 1.

Function
REQ-006 SHALL contain a 32x32 register file with one synchronous write port (W) and two combinational read ports (Rs=InstrD[25:21], Rt=InstrD[20:16]).
REQ-007 SHALL return 0 for reads of register 0 and SHALL ignore writes to register 0.
REQ-008 SHALL decode R-type instructions (op 0x00) by funct:
- add 0x20 -> ADD 0010
- sub 0x22 -> SUB 0110
- and 0x24 -> AND 0000
- or 0x25 -> OR 0001
- slt 0x2A -> SLT 0111
- control: RegWrite=1, RegDst=1, ALUSrc=0.
REQ-009 SHALL decode lw (0x23) as ADD, RegWrite=1, MemToReg=1, ALUSrc=1, RegDst=0.
REQ-010 SHALL decode sw (0x2B) as ADD, MemWrite=1, ALUSrc=1, RegWrite=0.
REQ-011 SHALL decode addi (0x08) as ADD, RegWrite=1, ALUSrc=1, RegDst=0.
REQ-012 SHALL form SignImmE as InstrD[15:0] sign-extended to 32 bits for every instruction.
REQ-013 SHALL treat InstrD==0x00000000 as a NOP: all control 0, IllegalE=0.
REQ-014 SHALL treat any other unsupported opcode or funct as a bubble (all control 0) with IllegalE=1 for that one E cycle.
REQ-015 SHALL register all E outputs on the rising edge of clk, giving a latency of exactly 1 cycle from InstrD to the E outputs.
REQ-016 SHALL keep an internal registered copy of the MemToReg and Rt values most recently sent to E.
REQ-017 SHALL assert StallD combinationally when that MemToReg copy is 1, its Rt is nonzero, and it equals the current Rs, or equals the current Rt for R-type/sw instructions.
REQ-018 SHALL, while StallD=1, load a bubble into E (control=0, IllegalE=0, data fields don't-care); the held InstrD SHALL then be re-decoded on the next cycle.
REQ-019 SHALL NOT let a bubble assert StallD, so a single lw produces a stall of exactly 1 cycle.
REQ-020 SHALL NOT block writes while StallD=1.

Reset
REQ-021 SHALL, while rst_n=0, clear every E output to 0 and clear the MemToReg/Rt copy to 0, making StallD=0.
REQ-022 SHALL reset register-file contents to 0.
REQ-023 SHALL, on reset assertion mid-stall, abandon the stall immediately and resume normal decode on the first clock after rst_n rises.

Configuration
REQ-024 SHALL, when REGFILE_BYPASS_EN is defined, forward ResultW to a read port in the same cycle when RegWriteW=1, WriteRegW!=0 and WriteRegW matches that read address.
REQ-025 SHALL, when REGFILE_BYPASS_EN is undefined, return the pre-write contents on such a same-cycle read; the new value then becomes visible on the next cycle.

Structure
REQ-026 SHALL place in the shared package the opcode constants, funct constants, the 4-bit ALU control encodings and the NOP constant, for use by both this block and the ALU.
REQ-027 SHALL implement the register file as sub-module register_file.
REQ-028 SHALL keep the decode table and the hazard logic in this module.

Verification
REQ-029 SHALL verify the add path: write r1=5 and r2=7 via W, then InstrD=add r3,r1,r2 (0x00221820) -> next cycle value1=5, value2=7, ALUControlE=0010, RegDstE=1, RdE=3, RegWriteE=1.
REQ-030 SHALL verify load-use: lw r4,8(r0) followed by add r5,r4,r4 -> StallD=1 for exactly 1 cycle, then one bubble in E, then the add in E with RsE=RtE=4.
REQ-031 SHALL verify sign extension: addi r6,r0,-1 (0x2006FFFF) -> SignImmE=0xFFFFFFFF, ALUSrcE=1, RtE=6, RegDstE=0.
REQ-032 SHALL verify illegal and NOP decode: opcode 0x3F -> IllegalE=1 for 1 cycle with all control 0; InstrD=0 -> IllegalE=0 with all control 0.
REQ-033 SHALL verify same-cycle write/read: write r7=0xDEAD while decoding or r8,r7,r0 -> value1=0xDEAD with REGFILE_BYPASS_EN, old value without it; writing r0 leaves r0 reading 0.
REQ-034 SHALL verify reset during a stall: drive rst_n low while StallD=1 -> all outputs 0 and StallD=0 at once, with decode resuming after release.
